// File: rtl/step_rate_meter.sv
// step_rate_meter
//
// Turns the raw step-sensor level into a steps-per-minute figure over a
// sliding window of WINDOW one-second bins, and keeps a lifetime step total.
// The window is paced by a 1 Hz strobe (sec_tick) from the system clock domain.
//
// Optional feature macro: STEP_DEBOUNCE_EN
//   When defined, the synchronized step level must hold for DEBOUNCE_CYC
//   consecutive cycles before it is accepted. This adds DEBOUNCE_CYC cycles of
//   latency and rejects shorter glitches.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-low reset
//   step_in     in   asynchronous raw sensor level, one rising edge = one step
//   sec_tick    in   one-cycle 1 Hz strobe, synchronous to clk
//   ppm         out  sum of the last WINDOW completed bins
//   ppm_upd     out  one-cycle pulse when ppm is refreshed
//   ppm_valid   out  high once WINDOW bins have completed since reset
//   total_steps out  lifetime step count, saturating at all ones
module step_rate_meter #(
  parameter int WINDOW       = 60,
  parameter int BIN_W        = 4,
  parameter int PPM_W        = 10,
  parameter int TOTAL_W      = 16,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_in,
  input  logic               sec_tick,
  output logic [PPM_W-1:0]   ppm,
  output logic               ppm_upd,
  output logic               ppm_valid,
  output logic [TOTAL_W-1:0] total_steps
);

  localparam int PTR_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int FILL_W = $clog2(WINDOW + 1);
  localparam logic [BIN_W-1:0]   BIN_MAX   = {BIN_W{1'b1}};
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = {TOTAL_W{1'b1}};
  localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(WINDOW - 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic               sync1_r;
  logic               sync2_r;
  logic               level_s;
  logic               prev_r;
  logic               step_evt_s;
  logic [BIN_W-1:0]   cur_bin_r;
  logic [BIN_W-1:0]   bin_buf_r [WINDOW];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PPM_W-1:0]   sum_r;
  logic               ppm_upd_r;
  logic               ppm_valid_r;
  logic [TOTAL_W-1:0] total_r;
  state_t             state_r;
  state_t             state_next_s;
  logic [FILL_W-1:0]  fill_cnt_r;
  logic [FILL_W-1:0]  fill_next_s;

  // Two-flop synchronizer for the asynchronous sensor level
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= step_in;
      sync2_r <= sync1_r;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  logic            filt_r;
  logic [DB_W-1:0] db_cnt_r;

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYC cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_r   <= 1'b0;
      db_cnt_r <= DB_W'(0);
    end else if (sync2_r == filt_r) begin
      db_cnt_r <= DB_W'(0);
    end else if (db_cnt_r == DB_W'(DEBOUNCE_CYC - 1)) begin
      filt_r   <= sync2_r;
      db_cnt_r <= DB_W'(0);
    end else begin
      db_cnt_r <= db_cnt_r + DB_W'(1);
    end
  end

  assign level_s = filt_r;
`else
  assign level_s = sync2_r;
`endif

  // Edge register: remembers the previous accepted level
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level_s;
    end
  end

  assign step_evt_s = level_s & ~prev_r;

  // Window datapath: current bin, ring buffer and running sum.
  // The running sum stays in range because it always equals the sum of
  // WINDOW saturated bins, so the subtract/add never wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < WINDOW; i++) begin
        bin_buf_r[i] <= BIN_W'(0);
      end
      sum_r     <= PPM_W'(0);
      wr_ptr_r  <= PTR_W'(0);
      cur_bin_r <= BIN_W'(0);
    end else if (sec_tick) begin
      sum_r               <= sum_r - PPM_W'(bin_buf_r[wr_ptr_r]) + PPM_W'(cur_bin_r);
      bin_buf_r[wr_ptr_r] <= cur_bin_r;
      wr_ptr_r            <= (wr_ptr_r == PTR_LAST) ? PTR_W'(0) : wr_ptr_r + PTR_W'(1);
      // A step coinciding with the tick belongs to the second just starting
      cur_bin_r           <= step_evt_s ? BIN_W'(1) : BIN_W'(0);
    end else if (step_evt_s && (cur_bin_r != BIN_MAX)) begin
      cur_bin_r <= cur_bin_r + BIN_W'(1);
    end else begin
      cur_bin_r <= cur_bin_r;
    end
  end

  // Lifetime total, independent of bin saturation
  always_ff @(posedge clk) begin
    if (!reset) begin
      total_r <= TOTAL_W'(0);
    end else if (step_evt_s && (total_r != TOTAL_MAX)) begin
      total_r <= total_r + TOTAL_W'(1);
    end else begin
      total_r <= total_r;
    end
  end

  // Fill/run state register and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_FILL;
      fill_cnt_r  <= FILL_W'(0);
      ppm_upd_r   <= 1'b0;
      ppm_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      fill_cnt_r  <= fill_next_s;
      ppm_upd_r   <= sec_tick;
      ppm_valid_r <= (state_next_s == ST_RUN);
    end
  end

  // Next-state logic: count ticks while filling, freeze once the window is full
  always_comb begin
    state_next_s = state_r;
    fill_next_s  = fill_cnt_r;
    case (state_r)
      ST_FILL: begin
        if (sec_tick) begin
          fill_next_s = fill_cnt_r + FILL_W'(1);
          if (fill_next_s == FILL_W'(WINDOW)) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_FILL;
          end
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_RUN: begin
        state_next_s = ST_RUN;
      end
      default: begin
        state_next_s = ST_FILL;
        fill_next_s  = FILL_W'(0);
      end
    endcase
  end

  assign ppm         = sum_r;
  assign ppm_upd     = ppm_upd_r;
  assign ppm_valid   = ppm_valid_r;
  assign total_steps = total_r;

endmodule

// File: tb/tb_step_rate_meter.sv
// Self-checking bench for step_rate_meter. A behavioural model keeps the
// completed bins in a queue and derives ppm, ppm_valid and total_steps from
// plain step/tick counts.
module tb_step_rate_meter;

  localparam int WINDOW       = 60;
  localparam int BIN_W        = 4;
  localparam int PPM_W        = 10;
  localparam int TOTAL_W      = 16;
  localparam int DEBOUNCE_CYC = 4;
  localparam int BIN_SAT      = 15;
  localparam int TOTAL_SAT    = 65535;
`ifdef STEP_DEBOUNCE_EN
  localparam int LAT_EXTRA = DEBOUNCE_CYC;
`else
  localparam int LAT_EXTRA = 0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               step_in = 1'b0;
  logic               sec_tick = 1'b0;
  logic [PPM_W-1:0]   ppm;
  logic               ppm_upd;
  logic               ppm_valid;
  logic [TOTAL_W-1:0] total_steps;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int win[$];
  int cur_cnt   = 0;
  int exp_total = 0;
  int ticks     = 0;

  step_rate_meter #(
    .WINDOW(WINDOW), .BIN_W(BIN_W), .PPM_W(PPM_W),
    .TOTAL_W(TOTAL_W), .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) dut (
    .clk(clk), .reset(reset), .step_in(step_in), .sec_tick(sec_tick),
    .ppm(ppm), .ppm_upd(ppm_upd), .ppm_valid(ppm_valid), .total_steps(total_steps)
  );

  always #5 clk = ~clk;

  function automatic int model_ppm();
    int s = 0;
    foreach (win[i]) s += win[i];
    return s;
  endfunction

  task automatic model_reset();
    win.delete();
    cur_cnt   = 0;
    exp_total = 0;
    ticks     = 0;
  endtask

  task automatic model_step();
    cur_cnt++;
    if (exp_total < TOTAL_SAT) exp_total++;
  endtask

  task automatic model_tick();
    win.push_back((cur_cnt > BIN_SAT) ? BIN_SAT : cur_cnt);
    if (win.size() > WINDOW) void'(win.pop_front());
    cur_cnt = 0;
    ticks++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input int exp_upd);
    check({tag, ".ppm"}, 32'(ppm), 32'(model_ppm()));
    check({tag, ".ppm_upd"}, 32'(ppm_upd), 32'(exp_upd));
    check({tag, ".ppm_valid"}, 32'(ppm_valid), (ticks >= WINDOW) ? 32'd1 : 32'd0);
    check({tag, ".total"}, 32'(total_steps), 32'(exp_total));
  endtask

  // n clean steps, each 2 cycles high and 2 cycles low
  task automatic pulse_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step_in = 1'b1;
      repeat (2) @(negedge clk);
      step_in = 1'b0;
      repeat (2) @(negedge clk);
      model_step();
    end
  endtask

  // Let pending steps settle, issue one tick, check refresh then quiet cycle
  task automatic tick(input string tag);
    repeat (4 + LAT_EXTRA) @(negedge clk);
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
    model_tick();
    check_outputs(tag, 1);
    @(negedge clk);
    check({tag, ".upd_off"}, 32'(ppm_upd), 32'd0);
  endtask

  initial begin
    // Reset held while step_in toggles and ticks arrive
    for (int i = 0; i < 5; i++) begin
      step_in  = ~step_in;
      sec_tick = i[0];
      @(negedge clk);
      model_reset();
      check_outputs("reset", 0);
    end
    step_in  = 1'b0;
    sec_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_outputs("post_reset_idle", 0);

    // Steady rate: 2 steps per second over a full window
    repeat (WINDOW) begin
      pulse_steps(2);
      tick("steady");
    end
    check("steady.final_ppm", 32'(ppm), 32'd120);

    // Window decay with no steps
    repeat (WINDOW / 2) begin
      pulse_steps(0);
      tick("decay");
    end
    check("decay.half_ppm", 32'(ppm), 32'd60);
    repeat (WINDOW / 2) begin
      pulse_steps(0);
      tick("decay");
    end
    check("decay.zero_ppm", 32'(ppm), 32'd0);

    // Bin saturation
    pulse_steps(20);
    tick("saturate");

    // Step event coinciding with the tick goes into the new bin
    pulse_steps(1);
    repeat (4 + LAT_EXTRA) @(negedge clk);
    step_in = 1'b1;
    repeat (2 + LAT_EXTRA) @(negedge clk);
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
    model_tick();
    model_step();
    check_outputs("coincident", 1);
    step_in = 1'b0;
    repeat (2) @(negedge clk);
    tick("coincident_next");

    // Back-to-back ticks
    pulse_steps(3);
    repeat (4 + LAT_EXTRA) @(negedge clk);
    sec_tick = 1'b1;
    @(negedge clk);
    model_tick();
    check_outputs("b2b_first", 1);
    @(negedge clk);
    sec_tick = 1'b0;
    model_tick();
    check_outputs("b2b_second", 1);
    @(negedge clk);
    check("b2b.upd_off", 32'(ppm_upd), 32'd0);

    // Randomized step counts per second
    repeat (25) begin
      pulse_steps($urandom_range(0, 18));
      tick("random");
    end

    // Refill to a known rate, then reset in RUN with a step mid-synchronizer
    repeat (WINDOW) begin
      pulse_steps(2);
      tick("refill");
    end
    check("pre_reset.ppm", 32'(ppm), 32'd120);
    step_in = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    step_in  = 1'b0;
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
    model_reset();
    check_outputs("midrun_reset", 0);
    reset = 1'b1;
    repeat (3 + LAT_EXTRA) @(negedge clk);
    check("discard.total", 32'(total_steps), 32'd0);

`ifdef STEP_DEBOUNCE_EN
    // A 2-cycle glitch is filtered out
    step_in = 1'b1;
    repeat (2) @(negedge clk);
    step_in = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch.total", 32'(total_steps), 32'(exp_total));
`endif

    // Fill again: ppm_valid only after a full window of new ticks
    repeat (WINDOW) begin
      pulse_steps(1);
      tick("post_reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_rate_meter.md
# step_rate_meter

Converts the raw step-sensor pulse stream into a steps-per-minute rate (`ppm`) over a sliding 60-second window, plus a lifetime step total. It sits directly upstream of the high-activity tracker and the step display. The tracker consumes `ppm` once per second, and the display consumes `total_steps`. The block runs on the fast system clock and is paced by a 1 Hz strobe.

## Interface
Parameters:
- `WINDOW`, 60: number of one-second bins in the sliding window.
- `BIN_W`, 4: width of one per-second bin; a bin saturates at 2^BIN_W−1 (15).
- `PPM_W`, 10: width of `ppm`; must hold WINDOW·(2^BIN_W−1) = 900.
- `TOTAL_W`, 16: width of `total_steps`.
- `DEBOUNCE_CYC`, 4: stable-cycle count, used only when `STEP_DEBOUNCE_EN` is defined.

Ports:
- `clk`, in, 1: system clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-low.
- `step_in`, in, 1: asynchronous raw sensor level; one rising edge is one step.
- `sec_tick`, in, 1: one-cycle strobe, once per second, synchronous to `clk`.
- `ppm`, out, PPM_W: sum of the last WINDOW completed bins.
- `ppm_upd`, out, 1: one-cycle pulse when `ppm` is refreshed.
- `ppm_valid`, out, 1: high once WINDOW bins have been completed since reset.
- `total_steps`, out, TOTAL_W: lifetime step count; saturates at 0xFFFF.

## Operation
- **Input path.** `step_in` passes through a 2-flop synchronizer, then a rising-edge detector, which produces `step_evt` (one cycle per step).
- **Current bin.** `cur_bin` increments on each `step_evt` and saturates at 15.
- **Ring buffer.** `WINDOW` entries of `BIN_W` bits, with write pointer `wr_ptr` (0..WINDOW−1), wrapping from WINDOW−1 to 0.
- **On `sec_tick`:**
  - `sum <= sum − buf[wr_ptr] + cur_bin`
  - `buf[wr_ptr] <= cur_bin`
  - `wr_ptr` advances.
  - `cur_bin` clears to 0, or loads 1 if `step_evt` occurs in the same cycle. That step belongs to the new second.
- **Arithmetic.** `sum` is PPM_W bits wide and never overflows or underflows by construction. `ppm` mirrors `sum`.
- **State machine** (2 states):
  - FILL: entered on reset. `fill_cnt` counts `sec_tick`s, and `ppm_valid` = 0. `ppm` still reports the partial sum of completed bins.
  - FILL → RUN on the tick where `fill_cnt` reaches WINDOW. In RUN, `ppm_valid` = 1 and `fill_cnt` is frozen.
  - RUN is left only by reset.
- **`total_steps`** increments on every `step_evt`, independent of bin saturation, and holds at 0xFFFF.
- **Reset (`reset`=0 at a clock edge)** clears in that same edge:
  - all buffer entries, `sum`, `cur_bin`, `wr_ptr`, `fill_cnt` and `total_steps`;
  - synchronizer and edge-detector flops;
  - state returns to FILL.
- **Reset takes priority** over a coincident `sec_tick` or `step_evt`. A step that is mid-synchronizer at reset is discarded.

## Timing
- Reset values: `ppm`=0, `ppm_upd`=0, `ppm_valid`=0, `total_steps`=0.
- Input latency: a `step_in` rise is counted into `cur_bin` and `total_steps` 3 clock edges later (2 sync flops plus the edge register).
- Output latency: `ppm`, `ppm_upd` and `ppm_valid` update on the edge following the `sec_tick` cycle (1-cycle latency). `ppm` is then stable until the next refresh.
- No handshake: the downstream stage samples `ppm` on `ppm_upd` or on its own 1 Hz clock.
- Back-to-back ticks: `sec_tick` in consecutive cycles is legal. Each tick closes one bin, and the second tick closes an empty bin unless a step arrives.
- `step_in` minimum high and low time is 2 `clk` cycles; faster toggles may be lost.

## Configuration
- Macro: `STEP_DEBOUNCE_EN`.
- Defined: after the synchronizer, a debounce counter requires the synchronized level to hold for `DEBOUNCE_CYC` consecutive cycles before the filtered level changes. `step_evt` is generated from the filtered level, adding DEBOUNCE_CYC cycles of latency, and glitches shorter than that are rejected.
- Not defined: no filter; `step_evt` comes directly from the synchronizer output with 3-cycle latency.

## Test plan
- **Reset:** hold `reset`=0 for 5 cycles while toggling `step_in` → `ppm`=0, `ppm_valid`=0, `total_steps`=0, `ppm_upd` never pulses.
- **Steady rate:** 2 steps per second for 60 ticks → `ppm` steps 2, 4, … 120. `ppm_valid` rises one cycle after the 60th tick, and `total_steps`=120.
- **Window decay:** continue from the previous scenario with no steps → `ppm`=60 after 30 more ticks and 0 after 60 more ticks. `ppm_valid` stays 1 and `total_steps` stays 120.
- **Bin saturation:** 20 steps in one second → that bin adds 15 to `ppm`, and `total_steps` increases by 20.
- **Coincident step and tick:** a `step_evt` in the same cycle as `sec_tick` → it is excluded from the bin being closed, and the next tick adds 1 for it.
- **Mid-run reset:** assert reset in RUN with `ppm`=120 → all outputs are 0 on the next edge, the FILL state is re-entered, and 60 new ticks are needed for `ppm_valid`. With `STEP_DEBOUNCE_EN`, a 2-cycle glitch on `step_in` leaves `total_steps` unchanged.
